// File: rtl/uninasoc_pkg.sv
// uninasoc_pkg: shared SoC constants for the AXI4-Lite GPIO slave.
// Holds the GPIO register offsets, AXI response codes, default GPIO widths,
// slave count and the write/read FSM state types.
package uninasoc_pkg;
    localparam int NUM_GPIO_IN  = 8;
    localparam int NUM_GPIO_OUT = 8;
    // The GPIO block occupies one crossbar slave port whenever it has any pins.
    localparam int BASE_AXI_SLAVES = 2;
    localparam int NUM_AXI_SLAVES  = BASE_AXI_SLAVES + ((NUM_GPIO_IN > 0 || NUM_GPIO_OUT > 0) ? 1 : 0);
    localparam logic [4:0] GPIO_DIN_OFFSET    = 5'h00;
    localparam logic [4:0] GPIO_DOUT_OFFSET   = 5'h04;
    localparam logic [4:0] GPIO_IRQEN_OFFSET  = 5'h08;
    localparam logic [4:0] GPIO_STATUS_OFFSET = 5'h0C;
    localparam logic [4:0] GPIO_EDGE_OFFSET   = 5'h10;
    localparam logic [4:0] GPIO_SET_OFFSET    = 5'h14;
    localparam logic [4:0] GPIO_CLR_OFFSET    = 5'h18;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction
endpackage

// File: rtl/gpio_edge_detect.sv
// gpio_edge_detect: input synchroniser, one-cycle delay copy and per-bit edge select.
// Ports: clk, rst (async active-high), pins (async inputs), edge_sel (0 rising,
// 1 falling), level (synchronised pins), edges (one-cycle pulse per selected edge).
module gpio_edge_detect #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] edges
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] dly;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            dly   <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pins};
            dly   <= chain[SYNC_STAGES-1];
        end
    end
    assign level = chain[SYNC_STAGES-1];
    // Edges come from the level itself, so flipping edge_sel on a steady pin never fires.
    assign edges = (edge_sel & dly & ~level) | (~edge_sel & level & ~dly);
endmodule

// File: rtl/axilite_gpio_irq.sv
// axilite_gpio_irq: AXI4-Lite GPIO slave with per-pin edge interrupts.
// Ports: clock_i, reset_i (async active-high); s_axilite_* AXI4-Lite slave;
// gpio_in_i async input pins; gpio_out_o registered outputs; irq_o registered
// level interrupt (OR of IRQ_STATUS & IRQ_EN).
// Build option: define GPIO_SET_CLR_EN to map DOUT_SET (0x14) and DOUT_CLR (0x18).
module axilite_gpio_irq #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_GPIO_IN    = uninasoc_pkg::NUM_GPIO_IN,
    parameter int NUM_GPIO_OUT   = uninasoc_pkg::NUM_GPIO_OUT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axilite_awaddr,
    input  logic                        s_axilite_awvalid,
    output logic                        s_axilite_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axilite_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axilite_wstrb,
    input  logic                        s_axilite_wvalid,
    output logic                        s_axilite_wready,
    output logic [1:0]                  s_axilite_bresp,
    output logic                        s_axilite_bvalid,
    input  logic                        s_axilite_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axilite_araddr,
    input  logic                        s_axilite_arvalid,
    output logic                        s_axilite_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axilite_rdata,
    output logic [1:0]                  s_axilite_rresp,
    output logic                        s_axilite_rvalid,
    input  logic                        s_axilite_rready,
    input  logic [NUM_GPIO_IN-1:0]      gpio_in_i,
    output logic [NUM_GPIO_OUT-1:0]     gpio_out_o,
    output logic                        irq_o
);
    import uninasoc_pkg::*;
    logic [NUM_GPIO_IN-1:0] din, edges, irq_en, irq_status, edge_sel;
    logic [NUM_GPIO_IN-1:0] irq_en_next, status_next, edge_next;
    logic [NUM_GPIO_OUT-1:0] dout, dout_next;
    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic aw_held, w_held, aw_take, w_take, do_wr, ar_take;
    logic wr_dout, wr_en, wr_stat, wr_edge, wr_set, wr_clr;
    logic [4:0] aw_off, cur_off, ar_off;
    logic [31:0] w_data, cur_data, cur_mask, wd, rd_val;
    logic [3:0] w_strb;
    logic unused;

    gpio_edge_detect #(.WIDTH(NUM_GPIO_IN), .SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk(clock_i), .rst(reset_i), .pins(gpio_in_i), .edge_sel(edge_sel),
        .level(din), .edges(edges)
    );

    function automatic logic mapped(input logic [4:0] off);
`ifdef GPIO_SET_CLR_EN
        return off <= GPIO_CLR_OFFSET;
`else
        return off <= GPIO_EDGE_OFFSET;
`endif
    endfunction

    assign s_axilite_awready = (w_state == W_IDLE) && !aw_held;
    assign s_axilite_wready  = (w_state == W_IDLE) && !w_held;
    assign s_axilite_bvalid  = w_state == W_RESP;
    assign s_axilite_arready = r_state == R_IDLE;
    assign s_axilite_rvalid  = r_state == R_DATA;
    assign aw_take = s_axilite_awvalid && s_axilite_awready;
    assign w_take  = s_axilite_wvalid && s_axilite_wready;
    assign ar_take = s_axilite_arvalid && s_axilite_arready;
    // Commit in the cycle the later of AW/W arrives, using whichever half was latched.
    assign do_wr    = (w_state == W_IDLE) && (aw_held || aw_take) && (w_held || w_take);
    assign cur_off  = aw_held ? aw_off : {s_axilite_awaddr[4:2], 2'b00};
    assign cur_data = w_held ? w_data : s_axilite_wdata;
    assign cur_mask = strb_mask(w_held ? w_strb : s_axilite_wstrb);
    assign wd       = cur_data & cur_mask;
    assign wr_dout  = do_wr && cur_off == GPIO_DOUT_OFFSET;
    assign wr_en    = do_wr && cur_off == GPIO_IRQEN_OFFSET;
    assign wr_stat  = do_wr && cur_off == GPIO_STATUS_OFFSET;
    assign wr_edge  = do_wr && cur_off == GPIO_EDGE_OFFSET;
`ifdef GPIO_SET_CLR_EN
    assign wr_set = do_wr && cur_off == GPIO_SET_OFFSET;
    assign wr_clr = do_wr && cur_off == GPIO_CLR_OFFSET;
`else
    assign wr_set = 1'b0;
    assign wr_clr = 1'b0;
`endif
    assign ar_off = {s_axilite_araddr[4:2], 2'b00};
    assign unused = ^{s_axilite_awaddr, s_axilite_araddr, cur_mask, wd};

    always_comb begin
        w_next      = do_wr ? W_RESP : (w_state == W_RESP && s_axilite_bready) ? W_IDLE : w_state;
        r_next      = ar_take ? R_DATA : (r_state == R_DATA && s_axilite_rready) ? R_IDLE : r_state;
        dout_next   = wr_dout ? (dout & ~cur_mask[NUM_GPIO_OUT-1:0]) | wd[NUM_GPIO_OUT-1:0] :
                      wr_set  ? dout | wd[NUM_GPIO_OUT-1:0] :
                      wr_clr  ? dout & ~wd[NUM_GPIO_OUT-1:0] : dout;
        irq_en_next = wr_en ? (irq_en & ~cur_mask[NUM_GPIO_IN-1:0]) | wd[NUM_GPIO_IN-1:0] : irq_en;
        edge_next   = wr_edge ? (edge_sel & ~cur_mask[NUM_GPIO_IN-1:0]) | wd[NUM_GPIO_IN-1:0] : edge_sel;
        // A new edge is OR-ed in after the W1C clear, so a coincident event survives.
        status_next = (irq_status & ~(wr_stat ? wd[NUM_GPIO_IN-1:0] : '0)) | edges;
        rd_val      = ar_off == GPIO_DIN_OFFSET    ? 32'(din) :
                      ar_off == GPIO_DOUT_OFFSET   ? 32'(dout) :
                      ar_off == GPIO_IRQEN_OFFSET  ? 32'(irq_en) :
                      ar_off == GPIO_STATUS_OFFSET ? 32'(irq_status) :
                      ar_off == GPIO_EDGE_OFFSET   ? 32'(edge_sel) : '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_off          <= '0;
            w_data          <= '0;
            w_strb          <= '0;
            s_axilite_bresp <= AXI_RESP_OKAY;
            s_axilite_rdata <= '0;
            s_axilite_rresp <= AXI_RESP_OKAY;
            dout            <= '0;
            irq_en          <= '0;
            irq_status      <= '0;
            edge_sel        <= '0;
            irq_o           <= 1'b0;
        end else begin
            aw_held    <= !do_wr && (aw_held || aw_take);
            w_held     <= !do_wr && (w_held || w_take);
            aw_off     <= aw_take ? {s_axilite_awaddr[4:2], 2'b00} : aw_off;
            w_data     <= w_take ? s_axilite_wdata : w_data;
            w_strb     <= w_take ? s_axilite_wstrb : w_strb;
            s_axilite_bresp <= do_wr ? (mapped(cur_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : s_axilite_bresp;
            s_axilite_rdata <= ar_take ? rd_val : s_axilite_rdata;
            s_axilite_rresp <= ar_take ? (mapped(ar_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : s_axilite_rresp;
            dout       <= dout_next;
            irq_en     <= irq_en_next;
            irq_status <= status_next;
            edge_sel   <= edge_next;
            irq_o      <= |(irq_status & irq_en);
        end
    end

    assign gpio_out_o = dout;
endmodule

// File: tb/tb_axilite_gpio_irq.sv
// tb_axilite_gpio_irq: self-checking bench for axilite_gpio_irq (scoreboard of expected reads/writes).
module tb_axilite_gpio_irq;
    localparam int NI = 8, NO = 8, SS = 2;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    logic clk = 0, rst = 1;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0] wstrb = 0;
    logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [NI-1:0] gpio_in = 0;
    logic [NO-1:0] gpio_out;
    logic irq;
    int n_checks = 0, n_fail = 0;
    logic [31:0] exp_data[$];
    logic [1:0] exp_resp[$];
    logic [31:0] ed, m_dout = 0;
    logic [1:0] er;

    always #5 clk = ~clk;

    axilite_gpio_irq #(.NUM_GPIO_IN(NI), .NUM_GPIO_OUT(NO), .SYNC_STAGES(SS)) dut (
        .clock_i(clk), .reset_i(rst),
        .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid), .s_axilite_wready(wready),
        .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid), .s_axilite_bready(bready),
        .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
        .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid), .s_axilite_rready(rready),
        .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .irq_o(irq)
    );

    // Called at a negedge; returns at a negedge with the response accepted when bready=1.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        logic ad, wd;
        ad = 0; wd = 0; lat = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(ad && wd) && lat < 20) begin
            if (awready) ad = 1;
            if (wready) wd = 1;
            @(posedge clk); @(negedge clk);
            if (ad) awvalid = 0;
            if (wd) wvalid = 0;
            lat++;
        end
        lat = 1;
        while (!bvalid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        resp = bresp;
        if (bready) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
        araddr = a; arvalid = 1; lat = 0;
        while (!arready && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        @(posedge clk); @(negedge clk);
        arvalid = 0; lat = 1;
        while (!rvalid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        d = rdata; resp = rresp;
        if (rready) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat;
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({irq, gpio_out, bvalid, rvalid} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: irq=%b gpio_out=%h bvalid=%b rvalid=%b, required all 0", irq, gpio_out, bvalid, rvalid);
        end
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_readies: got %b%b%b required 111", awready, wready, arready);
        end
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_data.push_back(32'h0); exp_resp.push_back(OKAY);
            axi_read(32'(i * 4), d, r, lat);
            ed = exp_data.pop_front(); er = exp_resp.pop_front();
            n_checks++;
            if (d !== ed || r !== er || lat !== 1) begin
                n_fail++; $display("FAIL reset_read_%0h: got %h/%b lat %0d, required %h/%b lat 1", i * 4, d, r, lat, ed, er);
            end
        end
    endtask

    task automatic test_dout();
        logic [31:0] d; logic [1:0] r; int lat;
        exp_resp.push_back(OKAY);
        axi_write(32'h04, 32'h000000A5, 4'b0001, r, lat);
        m_dout = 32'hA5;
        er = exp_resp.pop_front();
        n_checks++;
        if (r !== er || lat !== 1 || gpio_out !== m_dout[NO-1:0]) begin
            n_fail++; $display("FAIL dout_write: resp %b lat %0d gpio_out %h, required %b lat 1 gpio_out %h", r, lat, gpio_out, er, m_dout[NO-1:0]);
        end
        axi_write(32'h04, 32'h000000FF, 4'b0000, r, lat);
        n_checks++;
        if (gpio_out !== m_dout[NO-1:0]) begin
            n_fail++; $display("FAIL dout_strb0: gpio_out %h required %h", gpio_out, m_dout[NO-1:0]);
        end
        axi_write(32'h04, 32'h0000FF00, 4'b0010, r, lat);
        exp_data.push_back(m_dout); exp_resp.push_back(OKAY);
        axi_read(32'h04, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL dout_upper_lane: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d; logic [1:0] r; int lat, cnt;
        awaddr = 32'h10; awvalid = 1; bready = 0;
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        n_checks++;
        if (awready !== 0 || wready !== 1 || bvalid !== 0) begin
            n_fail++; $display("FAIL split_aw_only: awready %b wready %b bvalid %b, required 0 1 0", awready, wready, bvalid);
        end
        repeat (2) begin @(posedge clk); @(negedge clk); end
        wdata = 32'h3C; wstrb = 4'hF; wvalid = 1;
        exp_resp.push_back(OKAY);
        @(posedge clk); @(negedge clk);
        wvalid = 0;
        er = exp_resp.pop_front();
        n_checks++;
        if (bvalid !== 1 || bresp !== er) begin
            n_fail++; $display("FAIL split_bvalid: bvalid %b bresp %b, required 1 %b", bvalid, bresp, er);
        end
        cnt = 0;
        repeat (4) begin @(posedge clk); @(negedge clk); if (bvalid) cnt++; end
        n_checks++;
        if (cnt !== 4) begin
            n_fail++; $display("FAIL split_bvalid_hold: held %0d cycles, required 4", cnt);
        end
        bready = 1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bvalid !== 0 || awready !== 1 || wready !== 1) begin
            n_fail++; $display("FAIL split_release: bvalid %b awready %b wready %b, required 0 1 1", bvalid, awready, wready);
        end
        exp_data.push_back(32'h3C); exp_resp.push_back(OKAY);
        axi_read(32'h10, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL split_readback: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_back_to_back();
        awaddr = 32'h04; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h04; arvalid = 1;
        exp_data.push_back(m_dout); exp_resp.push_back(OKAY);
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        m_dout = 32'h5A;
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (rvalid !== 1 || rdata !== ed || rresp !== er) begin
            n_fail++; $display("FAIL rw_same_cycle_read: rvalid %b rdata %h rresp %b, required 1 %h %b", rvalid, rdata, rresp, ed, er);
        end
        n_checks++;
        if (bvalid !== 1 || bresp !== OKAY) begin
            n_fail++; $display("FAIL rw_same_cycle_write: bvalid %b bresp %b, required 1 00", bvalid, bresp);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (gpio_out !== m_dout[NO-1:0] || rvalid !== 0 || bvalid !== 0) begin
            n_fail++; $display("FAIL rw_same_cycle_after: gpio_out %h rvalid %b bvalid %b, required %h 0 0", gpio_out, rvalid, bvalid, m_dout[NO-1:0]);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; int lat;
        exp_data.push_back(32'h0); exp_resp.push_back(SLVERR);
        axi_read(32'h1C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL unmapped_read: got %h/%b required %h/%b", d, r, ed, er);
        end
        exp_resp.push_back(SLVERR);
        axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, r, lat);
        er = exp_resp.pop_front();
        n_checks++;
        if (r !== er || gpio_out !== m_dout[NO-1:0]) begin
            n_fail++; $display("FAIL unmapped_write: resp %b gpio_out %h, required %b %h", r, gpio_out, er, m_dout[NO-1:0]);
        end
`ifdef GPIO_SET_CLR_EN
        axi_write(32'h04, 32'h0F, 4'hF, r, lat);
        axi_write(32'h14, 32'hF0, 4'hF, r, lat);
        n_checks++;
        if (r !== OKAY || gpio_out !== 8'hFF) begin
            n_fail++; $display("FAIL dout_set: resp %b gpio_out %h, required 00 ff", r, gpio_out);
        end
        axi_write(32'h18, 32'h0F, 4'hF, r, lat);
        m_dout = 32'hF0;
        n_checks++;
        if (r !== OKAY || gpio_out !== m_dout[NO-1:0]) begin
            n_fail++; $display("FAIL dout_clr: resp %b gpio_out %h, required 00 %h", r, gpio_out, m_dout[NO-1:0]);
        end
        exp_data.push_back(32'h0); exp_resp.push_back(OKAY);
`else
        axi_write(32'h14, 32'hFF, 4'hF, r, lat);
        n_checks++;
        if (r !== SLVERR || gpio_out !== m_dout[NO-1:0]) begin
            n_fail++; $display("FAIL set_unmapped: resp %b gpio_out %h, required 10 %h", r, gpio_out, m_dout[NO-1:0]);
        end
        exp_data.push_back(32'h0); exp_resp.push_back(SLVERR);
`endif
        axi_read(32'h14, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL read_0x14: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(32'h10, 32'h00, 4'hF, r, lat);
        axi_write(32'h08, 32'h01, 4'hF, r, lat);
        gpio_in[0] = 1; lat = 0;
        while (!irq && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        n_checks++;
        if (lat !== SS + 2) begin
            n_fail++; $display("FAIL irq_latency: %0d cycles, required %0d", lat, SS + 2);
        end
        exp_data.push_back(32'h01); exp_resp.push_back(OKAY);
        axi_read(32'h0C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL status_rise: got %h/%b required %h/%b", d, r, ed, er);
        end
        exp_data.push_back(32'h01); exp_resp.push_back(OKAY);
        axi_read(32'h00, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL din_read: got %h/%b required %h/%b", d, r, ed, er);
        end
        axi_write(32'h0C, 32'h01, 4'hF, r, lat);
        n_checks++;
        if (irq !== 0) begin
            n_fail++; $display("FAIL irq_w1c: irq %b required 0", irq);
        end
        gpio_in[1] = 1;
        repeat (6) @(negedge clk);
        exp_data.push_back(32'h02); exp_resp.push_back(OKAY);
        axi_read(32'h0C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er || irq !== 0) begin
            n_fail++; $display("FAIL status_masked: got %h/%b irq %b required %h/%b irq 0", d, r, irq, ed, er);
        end
        axi_write(32'h10, 32'h04, 4'hF, r, lat);
        gpio_in[2] = 1;
        repeat (6) @(negedge clk);
        exp_data.push_back(32'h02); exp_resp.push_back(OKAY);
        axi_read(32'h0C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL falling_sel_ignores_rise: got %h/%b required %h/%b", d, r, ed, er);
        end
        gpio_in[2] = 0;
        repeat (6) @(negedge clk);
        exp_data.push_back(32'h06); exp_resp.push_back(OKAY);
        axi_read(32'h0C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er) begin
            n_fail++; $display("FAIL falling_edge: got %h/%b required %h/%b", d, r, ed, er);
        end
        gpio_in[0] = 0;
        repeat (6) @(negedge clk);
        axi_write(32'h0C, 32'h07, 4'hF, r, lat);
        gpio_in[0] = 1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        awaddr = 32'h0C; wdata = 32'h01; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0;
        @(posedge clk); @(negedge clk);
        exp_data.push_back(32'h01); exp_resp.push_back(OKAY);
        axi_read(32'h0C, d, r, lat);
        ed = exp_data.pop_front(); er = exp_resp.pop_front();
        n_checks++;
        if (d !== ed || r !== er || irq !== 1) begin
            n_fail++; $display("FAIL set_beats_w1c: got %h/%b irq %b required %h/%b irq 1", d, r, irq, ed, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, held; logic [1:0] r; int lat;
        gpio_in = '0; rready = 0;
        axi_read(32'h04, held, r, lat);
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (rvalid !== 1 || rdata !== held || held !== m_dout) begin
            n_fail++; $display("FAIL rvalid_hold: rvalid %b rdata %h first %h, required 1 %h", rvalid, rdata, held, m_dout);
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (rvalid !== 0 || gpio_out !== 0 || irq !== 0 || arready !== 1) begin
            n_fail++; $display("FAIL reset_mid: rvalid %b gpio_out %h irq %b arready %b, required 0 00 0 1", rvalid, gpio_out, irq, arready);
        end
        @(negedge clk);
        rst = 0; rready = 1; m_dout = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_data.push_back(32'h0); exp_resp.push_back(OKAY);
            axi_read(32'(i * 4), d, r, lat);
            ed = exp_data.pop_front(); er = exp_resp.pop_front();
            n_checks++;
            if (d !== ed || r !== er) begin
                n_fail++; $display("FAIL post_reset_read_%0h: got %h/%b required %h/%b", i * 4, d, r, ed, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dout();
        test_split_write();
        test_back_to_back();
        test_unmapped();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
